// File: rtl/bp_pkg.sv
// Shared types and encodings for the branch predictor.
//   ctr_t        : 2-bit saturating counter (bit 1 is the predicted direction)
//   CTR_*        : counter encodings, strong-NT .. strong-T
//   bp_state_t   : predictor FSM states (table init sweep, normal run)
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

endpackage

// File: rtl/sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
//   state_old : current counter value
//   taken     : resolved branch outcome
//   state     : counter value after the update (saturates at 00 / 11)
module sat_ctr2
  import bp_pkg::*;
(
  input  ctr_t state_old,
  input  logic taken,
  output ctr_t state
);

  always_comb begin
    state = state_old;
    if (taken) begin
      if (state_old != CTR_ST) state = ctr_t'(state_old + 2'd1);
    end else begin
      if (state_old != CTR_SNT) state = ctr_t'(state_old - 2'd1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: table of 2-bit counters indexed by
// PC XOR GHR (GSHARE_HASH_EN defined) or by the GHR alone (macro undefined).
// A sweep after reset writes CTR_INIT to every entry before predicting.
//   clk, rst        : clock, synchronous active-high reset
//   ready           : high once the init sweep has completed
//   pred_valid/pc   : fetch prediction request
//   pred_taken      : predicted direction (combinational)
//   pred_idx/ghr    : table index and pre-shift GHR checkpoint
//   upd_valid/idx/ghr/taken/mispredict : resolve-stage update and GHR repair
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned GHR_WIDTH = 4,
  parameter int unsigned PHT_IDX_W = 6,
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned PC_LSB    = 2,
  parameter ctr_t        CTR_INIT  = CTR_WNT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 pred_valid,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic [GHR_WIDTH-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict
);

  localparam int unsigned DEPTH = 1 << PHT_IDX_W;

  bp_state_t            state;
  bp_state_t            state_next;
  logic                 run;
  logic [PHT_IDX_W-1:0] init_ptr;
  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] ghr_next;
  ctr_t                 pht [DEPTH];
  logic [PHT_IDX_W-1:0] idx;
  ctr_t                 upd_next;
  logic                 wr_en;
  logic [PHT_IDX_W-1:0] wr_idx;
  ctr_t                 wr_data;
  logic                 unused_pc;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= BP_INIT;
    else     state <= state_next;
  end

  // FSM next state: leave INIT once the last entry has been written
  always_comb begin
    state_next = state;
    if (state == BP_INIT && init_ptr == '1) state_next = BP_RUN;
  end

  // FSM outputs
  always_comb begin
    run   = 1'b0;
    ready = 1'b0;
    if (state == BP_RUN) begin
      run   = 1'b1;
      ready = 1'b1;
    end
  end

  // Init sweep pointer; wraps back to zero as the sweep completes
  always_ff @(posedge clk) begin
    if (rst)                  init_ptr <= '0;
    else if (state == BP_INIT) init_ptr <= init_ptr + PHT_IDX_W'(1);
  end

  // Prediction index
`ifdef GSHARE_HASH_EN
  assign idx = pred_pc[PC_LSB +: PHT_IDX_W] ^ PHT_IDX_W'(ghr);
`else
  assign idx = PHT_IDX_W'(ghr);
`endif
  // Keeps the PC port (or its unhashed bits) from reading as dangling
  assign unused_pc = ^pred_pc;

  assign pred_idx   = idx;
  assign pred_ghr   = ghr;
  assign pred_taken = run ? pht[idx][1] : 1'b0;

  sat_ctr2 u_sat_ctr2 (
    .state_old (pht[upd_idx]),
    .taken     (upd_taken),
    .state     (upd_next)
  );

  // Single table write port: sweep during INIT, resolve updates during RUN
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_next;
    if (!rst) begin
      if (!run) begin
        wr_en   = 1'b1;
        wr_idx  = init_ptr;
        wr_data = CTR_INIT;
      end else if (upd_valid) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

  // History: a mispredict repair takes priority over the speculative shift
  // because the same-cycle fetch is being flushed.
  always_comb begin
    ghr_next = ghr;
    if (run) begin
      if (upd_valid && upd_mispredict) ghr_next = GHR_WIDTH'({upd_taken, upd_ghr} >> 1);
      else if (pred_valid)             ghr_next = GHR_WIDTH'({pred_taken, ghr} >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else     ghr <= ghr_next;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (default parameters).
// Expected values come from a bench-side table/GHR model, are pushed to a
// queue when stimulus is applied and popped when the DUT result is sampled.
module tb_gshare_predictor;
  import bp_pkg::*;

  localparam int unsigned GW    = 4;
  localparam int unsigned IW    = 6;
  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          pred_valid;
  logic [PW-1:0] pred_pc;
  logic          pred_taken;
  logic [IW-1:0] pred_idx;
  logic [GW-1:0] pred_ghr;
  logic          upd_valid;
  logic [IW-1:0] upd_idx;
  logic [GW-1:0] upd_ghr;
  logic          upd_taken;
  logic          upd_mispredict;

  gshare_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks   = 0;
  int            failures = 0;
  logic [1:0]    m_pht [DEPTH];
  logic [GW-1:0] m_ghr;
  logic [31:0]   obs;

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : 2'(c + 2'd1);
    else   return (c == 2'b00) ? 2'b00 : 2'(c - 2'd1);
  endfunction

  task automatic push_exp(input string name, input logic [31:0] val);
    exp_t x;
    x.name = name;
    x.val  = val;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    pred_valid     = 1'b0;
    upd_valid      = 1'b0;
    upd_idx        = '0;
    upd_ghr        = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic drive_upd(input logic [IW-1:0] idx, input logic taken,
                           input logic mis, input logic [GW-1:0] ghr);
    upd_valid      = 1'b1;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_mispredict = mis;
    upd_ghr        = ghr;
  endtask

  // Counts edges from reset release until ready; result pushed/compared by caller
  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 2'b01;
    m_ghr = '0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    pred_pc = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_ready", 0);
    push_exp("reset_ghr", 0);
    push_exp("reset_taken", 0);
    e = exp_q.pop_front(); obs = 32'(ready); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    rst = 1'b0;
    push_exp("sweep_len", 64);
    wait_ready(n);
    e = exp_q.pop_front(); obs = 32'(n); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    for (int i = 0; i < DEPTH; i++) begin
      push_exp($sformatf("init_entry_%0d", i), 32'(m_pht[i]));
      e = exp_q.pop_front(); obs = 32'(dut.pht[i]); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    end
    push_exp("init_taken", 0);
    e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
  endtask

  task automatic test_saturation();
    logic t;
    // steer the GHR to 0101 so predictions read entry 5
    drive_upd(6'd0, 1'b0, 1'b1, 4'b1010);
    m_pht[0] = m_sat(m_pht[0], 1'b0);
    m_ghr    = {1'b0, 3'b101};
    push_exp("sat_steer_ghr", 32'(m_ghr));
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    for (int k = 0; k < 8; k++) begin
      t = (k < 4);
      drive_upd(6'd5, t, 1'b0, 4'b0000);
      #1;
      // same-cycle read sees the pre-write counter
      push_exp($sformatf("sat_preread_%0d", k), 32'(m_pht[5][1]));
      e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
      m_pht[5] = m_sat(m_pht[5], t);
      push_exp($sformatf("sat_ctr_%0d", k), 32'(m_pht[5]));
      push_exp($sformatf("sat_taken_%0d", k), 32'(m_pht[5][1]));
      @(posedge clk); #1;
      idle();
      e = exp_q.pop_front(); obs = 32'(dut.pht[5]); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
      e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    end
    push_exp("sat_ghr_untouched", 32'(m_ghr));
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
  endtask

  task automatic test_spec_ghr();
    logic p;
    drive_upd(6'd20, 1'b0, 1'b1, 4'b0000);
    m_pht[20] = m_sat(m_pht[20], 1'b0);
    m_ghr     = 4'b0000;
    @(posedge clk); #1;
    // train entries 0 and 8 towards taken
    for (int k = 0; k < 4; k++) begin
      drive_upd((k < 2) ? 6'd0 : 6'd8, 1'b1, 1'b0, 4'b0000);
      m_pht[(k < 2) ? 0 : 8] = m_sat(m_pht[(k < 2) ? 0 : 8], 1'b1);
      @(posedge clk); #1;
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      pred_valid = 1'b1;
      #1;
      p = m_pht[m_ghr][1];
      push_exp($sformatf("spec_ckpt_%0d", k), 32'(m_ghr));
      push_exp($sformatf("spec_taken_%0d", k), 32'(p));
      e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
      e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
      m_ghr = {p, m_ghr[GW-1:1]};
      @(posedge clk); #1;
    end
    pred_valid = 1'b0;
    push_exp("spec_ghr_final", 32'(4'b1100));
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    push_exp("spec_ghr_model", 32'(m_ghr));
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
  endtask

  task automatic test_mispredict_restore();
    pred_valid = 1'b1;
    drive_upd(6'd3, 1'b1, 1'b1, 4'b0101);
    m_pht[3] = m_sat(m_pht[3], 1'b1);
    m_ghr    = 4'b1010;
    push_exp("restore_ghr", 32'(m_ghr));
    push_exp("restore_ctr", 32'(m_pht[3]));
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(dut.pht[3]); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
  endtask

  task automatic test_hash();
    logic [IW-1:0] xi;
    drive_upd(6'd30, 1'b0, 1'b1, 4'b0110);
    m_pht[30] = m_sat(m_pht[30], 1'b0);
    m_ghr     = 4'b0011;
    @(posedge clk); #1;
    idle();
    pred_pc = 32'h0000_00A8;
`ifdef GSHARE_HASH_EN
    xi = 6'b101001;
`else
    xi = 6'b000011;
`endif
    #1;
    push_exp("hash_idx", 32'(xi));
    push_exp("hash_taken", 32'(m_pht[xi][1]));
    e = exp_q.pop_front(); obs = 32'(pred_idx); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    pred_pc = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    // mid-sweep: requests are ignored, then reset restarts the sweep
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    pred_valid = 1'b1;
    drive_upd(6'd1, 1'b1, 1'b1, 4'b0110);
    @(posedge clk); #1;
    idle();
    push_exp("sweep_ready_low", 0);
    push_exp("sweep_taken_low", 0);
    push_exp("sweep_ghr_ignored", 0);
    e = exp_q.pop_front(); obs = 32'(ready); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_taken); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp("midsweep_len", 64);
    wait_ready(n);
    e = exp_q.pop_front(); obs = 32'(n); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    // mid-run with non-zero history
    drive_upd(6'd2, 1'b1, 1'b1, 4'b0000);
    m_ghr = 4'b1000;
    push_exp("run_ghr_set", 32'(m_ghr));
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    rst = 1'b1;
    push_exp("run_rst_ready", 0);
    push_exp("run_rst_ghr", 0);
    @(posedge clk); #1;
    e = exp_q.pop_front(); obs = 32'(ready); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    e = exp_q.pop_front(); obs = 32'(pred_ghr); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
    rst = 1'b0;
    push_exp("rerun_len", 64);
    wait_ready(n);
    e = exp_q.pop_front(); obs = 32'(n); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    push_exp("rerun_entry2", 32'(m_pht[2]));
    e = exp_q.pop_front(); obs = 32'(dut.pht[2]); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %0h want %0h", e.name, obs, e.val); end
  endtask

  initial begin
    rst = 1'b1;
    pred_pc = '0;
    idle();
    m_ghr = '0;
    test_reset();
    test_saturation();
    test_spec_ghr();
    test_mispredict_restore();
    test_hash();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
